// File: rtl/ccip_dbg_trace_ctrl_if.sv
// Bundle of event-tap, CSR-command, readout and status signals between the CCI-P debug tap
// and the trace controller.
interface ccip_dbg_trace_ctrl_if #(
  parameter int DEPTH_LOG2 = 9
);
  logic [7:0]            ev_vec;
  logic [15:0]           ev_tag;
  logic                  cfg_arm;
  logic                  cfg_stop;
  logic                  cfg_clear;
  logic [7:0]            cfg_capt_mask;
  logic [7:0]            cfg_trig_mask;
  logic [DEPTH_LOG2-1:0] cfg_post_cnt;
  logic                  rd_req;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  rd_valid;
  logic [63:0]           rd_data;
  logic [1:0]            st_state;
  logic [DEPTH_LOG2-1:0] st_wr_ptr;
  logic                  st_wrapped;
  logic                  st_triggered;
  logic [DEPTH_LOG2-1:0] st_trig_ptr;

  modport master (
    output ev_vec, ev_tag, cfg_arm, cfg_stop, cfg_clear, cfg_capt_mask, cfg_trig_mask,
           cfg_post_cnt, rd_req, rd_addr,
    input  rd_valid, rd_data, st_state, st_wr_ptr, st_wrapped, st_triggered, st_trig_ptr
  );

  modport slave (
    input  ev_vec, ev_tag, cfg_arm, cfg_stop, cfg_clear, cfg_capt_mask, cfg_trig_mask,
           cfg_post_cnt, rd_req, rd_addr,
    output rd_valid, rd_data, st_state, st_wr_ptr, st_wrapped, st_triggered, st_trig_ptr
  );
endinterface

// File: rtl/ccip_dbg_trace_ctrl.sv
// Arm/trigger/capture controller for the CCI-P debug tap: timestamps event strobes into a
// ring buffer, stops a programmed number of entries after a trigger, and serves CSR readout.
module ccip_dbg_trace_ctrl #(
  parameter int DEPTH_LOG2 = 9,
  parameter int TS_W       = 32
) (
  input  logic                  pClk,
  input  logic                  pck_cp2af_softReset_n,
  ccip_dbg_trace_ctrl_if.slave  dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptrT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT           state;
  logic [TS_W-1:0] tsCount;
  ptrT             wrPtr;
  ptrT             trigPtr;
  ptrT             postLeft;
  logic            wrapped;
  logic            triggered;

  logic            capHit;
  logic            trgHit;
  logic            wrEn;
  logic [63:0]     wrEntry;

  logic [63:0]     mem [DEPTH];
  logic [63:0]     ramQ;
  logic            rdPipe;
  logic            rdValid;
  logic [63:0]     rdData;

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      tsCount <= '0;
    end else begin
      tsCount <= tsCount + 1'b1;
    end
  end

  // Clear and stop both suppress the write of their cycle, which also keeps a coincident trigger out.
  always_comb begin
    capHit  = |(dbg.ev_vec & dbg.cfg_capt_mask);
    trgHit  = |(dbg.ev_vec & dbg.cfg_trig_mask);
    wrEn    = 1'b0;
    wrEntry = {32'(tsCount), dbg.ev_vec, dbg.ev_tag, 8'h00};
    if (!dbg.cfg_clear && !dbg.cfg_stop) begin
      unique case (state)
        ARMED:   wrEn = capHit || trgHit;
        POST:    wrEn = capHit;
        default: wrEn = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      state     <= IDLE;
      wrPtr     <= '0;
      trigPtr   <= '0;
      postLeft  <= '0;
      wrapped   <= 1'b0;
      triggered <= 1'b0;
    end else if (dbg.cfg_clear) begin
      state     <= IDLE;
      wrPtr     <= '0;
      trigPtr   <= '0;
      postLeft  <= '0;
      wrapped   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + 1'b1;
        if (&wrPtr) begin
          wrapped <= 1'b1;
        end
      end
      unique case (state)
        IDLE, DONE: begin
          if (dbg.cfg_arm && !dbg.cfg_stop) begin
            state     <= ARMED;
            wrPtr     <= '0;
            trigPtr   <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
          end
        end
        ARMED: begin
          if (dbg.cfg_stop) begin
            state <= DONE;
          end else if (trgHit) begin
            trigPtr   <= wrPtr;
            triggered <= 1'b1;
            postLeft  <= dbg.cfg_post_cnt;
            state     <= (dbg.cfg_post_cnt == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (dbg.cfg_stop) begin
            state <= DONE;
          end else if (capHit) begin
            postLeft <= postLeft - 1'b1;
            if (postLeft == ptrT'(1)) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Trace RAM has no reset so it maps onto block RAM; read-before-write gives old data on collision.
  always_ff @(posedge pClk) begin
    if (wrEn) begin
      mem[wrPtr] <= wrEntry;
    end
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      ramQ    <= '0;
      rdPipe  <= 1'b0;
      rdValid <= 1'b0;
      rdData  <= '0;
    end else begin
      if (dbg.rd_req) begin
        ramQ <= mem[dbg.rd_addr];
      end
      rdPipe  <= dbg.rd_req;
      rdValid <= rdPipe;
      rdData  <= ramQ;
    end
  end

  assign dbg.rd_valid     = rdValid;
  assign dbg.rd_data      = rdData;
  assign dbg.st_state     = state;
  assign dbg.st_wr_ptr    = wrPtr;
  assign dbg.st_wrapped   = wrapped;
  assign dbg.st_triggered = triggered;
  assign dbg.st_trig_ptr  = trigPtr;

endmodule

// File: tb/tb_ccip_dbg_trace_ctrl.sv
// Scenario bench for the debug trace controller, run with a 16-entry buffer so wrap is cheap;
// readout expectations go through a scoreboard queue.
module tb_ccip_dbg_trace_ctrl;

  localparam int DL2 = 4;

  logic        pClk = 1'b0;
  logic        rstN;
  int          checks   = 0;
  int          failures = 0;
  int          cycleCnt = 0;
  logic [63:0] expQ[$];

  ccip_dbg_trace_ctrl_if #(.DEPTH_LOG2(DL2)) bus ();

  ccip_dbg_trace_ctrl #(.DEPTH_LOG2(DL2), .TS_W(32)) dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (rstN),
    .dbg                   (bus)
  );

  always #5 pClk = ~pClk;

  // Reference timestamp: cycles since reset release, as seen between clock edges.
  always @(posedge pClk or negedge rstN) begin
    if (!rstN) cycleCnt <= 0;
    else       cycleCnt <= cycleCnt + 1;
  end

  task automatic applyStimulus(input logic [7:0] ev, input logic [15:0] tag, output logic [63:0] entry);
    entry = {32'(cycleCnt), ev, tag, 8'h00};
    bus.ev_vec = ev;
    bus.ev_tag = tag;
    @(negedge pClk);
    bus.ev_vec = 8'h00;
    bus.ev_tag = 16'h0000;
  endtask

  task automatic pulseCmd(input logic arm, input logic stop, input logic clear);
    bus.cfg_arm   = arm;
    bus.cfg_stop  = stop;
    bus.cfg_clear = clear;
    @(negedge pClk);
    bus.cfg_arm   = 1'b0;
    bus.cfg_stop  = 1'b0;
    bus.cfg_clear = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.ev_vec = '0; bus.ev_tag = '0; bus.cfg_arm = 0; bus.cfg_stop = 0; bus.cfg_clear = 0;
    bus.cfg_capt_mask = '0; bus.cfg_trig_mask = '0; bus.cfg_post_cnt = '0;
    bus.rd_req = 0; bus.rd_addr = '0;
    #12;
    checks++; if (bus.st_state !== 2'd0) begin failures++; $display("[TB] FAIL rst_state got=%0d exp=0", bus.st_state); end
    checks++; if (bus.st_wr_ptr !== '0) begin failures++; $display("[TB] FAIL rst_wr_ptr got=%0d exp=0", bus.st_wr_ptr); end
    checks++; if (bus.st_wrapped !== 1'b0) begin failures++; $display("[TB] FAIL rst_wrapped got=%b exp=0", bus.st_wrapped); end
    checks++; if (bus.st_triggered !== 1'b0) begin failures++; $display("[TB] FAIL rst_triggered got=%b exp=0", bus.st_triggered); end
    checks++; if (bus.st_trig_ptr !== '0) begin failures++; $display("[TB] FAIL rst_trig_ptr got=%0d exp=0", bus.st_trig_ptr); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 64'd0) begin failures++; $display("[TB] FAIL rst_rd_data got=%h exp=0", bus.rd_data); end
    @(negedge pClk);
    rstN = 1'b1;
  endtask

  task automatic test_capture();
    logic [63:0]    e;
    logic [DL2-1:0] ra[$];
    logic [63:0]    re[$];
    logic [63:0]    exp;
    int             n;
    bus.cfg_capt_mask = 8'h01;
    bus.cfg_trig_mask = 8'h00;
    pulseCmd(1, 0, 0);
    for (int k = 0; k < 40 && cycleCnt < 10; k++) @(negedge pClk);
    applyStimulus(8'h01, 16'hA000, e); ra.push_back(0); re.push_back(e);
    applyStimulus(8'h01, 16'hA001, e); ra.push_back(1); re.push_back(e);
    for (int k = 0; k < 40 && cycleCnt < 15; k++) @(negedge pClk);
    applyStimulus(8'h01, 16'hA002, e); ra.push_back(2); re.push_back(e);
    checks++; if (re[2][63:32] !== 32'd15) begin failures++; $display("[TB] FAIL cap_ts15 got=%0d exp=15", re[2][63:32]); end
    checks++; if (bus.st_wr_ptr !== 4'd3) begin failures++; $display("[TB] FAIL cap_wr_ptr got=%0d exp=3", bus.st_wr_ptr); end
    checks++; if (bus.st_state !== 2'd1) begin failures++; $display("[TB] FAIL cap_state got=%0d exp=1", bus.st_state); end
    n = ra.size();
    for (int i = 0; i < n + 3; i++) begin
      checks++;
      if (bus.rd_valid !== (i >= 2 && i < n + 2)) begin
        failures++; $display("[TB] FAIL cap_rd_valid[%0d] got=%b", i, bus.rd_valid);
      end
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL cap_rd_extra got=%h exp=none", bus.rd_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rd_data !== exp) begin failures++; $display("[TB] FAIL cap_rd_data got=%h exp=%h", bus.rd_data, exp); end
        end
      end
      if (i < n) begin expQ.push_back(re[i]); bus.rd_req = 1; bus.rd_addr = ra[i]; end
      else bus.rd_req = 0;
      @(negedge pClk);
    end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL cap_rd_missing got=%0d exp=0", expQ.size()); expQ.delete(); end
  endtask

  task automatic test_trigger_post();
    logic [63:0] e;
    pulseCmd(0, 0, 1);
    bus.cfg_capt_mask = 8'hFF;
    bus.cfg_trig_mask = 8'h80;
    bus.cfg_post_cnt  = 4'd4;
    pulseCmd(1, 0, 0);
    applyStimulus(8'h01, 16'hB000, e);
    applyStimulus(8'h02, 16'hB001, e);
    applyStimulus(8'h80, 16'hB002, e);
    checks++; if (bus.st_state !== 2'd2) begin failures++; $display("[TB] FAIL trg_state_post got=%0d exp=2", bus.st_state); end
    checks++; if (bus.st_triggered !== 1'b1) begin failures++; $display("[TB] FAIL trg_triggered got=%b exp=1", bus.st_triggered); end
    for (int i = 0; i < 3; i++) applyStimulus(8'h01, 16'hB100 + 16'(i), e);
    checks++; if (bus.st_state !== 2'd2) begin failures++; $display("[TB] FAIL trg_state_3rd got=%0d exp=2", bus.st_state); end
    applyStimulus(8'h04, 16'hB103, e);
    checks++; if (bus.st_state !== 2'd3) begin failures++; $display("[TB] FAIL trg_state_done got=%0d exp=3", bus.st_state); end
    applyStimulus(8'h01, 16'hB104, e);
    applyStimulus(8'h80, 16'hB105, e);
    checks++; if (bus.st_wr_ptr !== 4'd7) begin failures++; $display("[TB] FAIL trg_wr_ptr got=%0d exp=7", bus.st_wr_ptr); end
    checks++; if (bus.st_trig_ptr !== 4'd2) begin failures++; $display("[TB] FAIL trg_trig_ptr got=%0d exp=2", bus.st_trig_ptr); end
    checks++; if (bus.st_state !== 2'd3) begin failures++; $display("[TB] FAIL trg_state_hold got=%0d exp=3", bus.st_state); end
  endtask

  task automatic test_wrap();
    logic [63:0]    ent[20];
    logic [DL2-1:0] ra[$];
    logic [63:0]    re[$];
    logic [63:0]    exp;
    int             n;
    pulseCmd(0, 0, 1);
    bus.cfg_capt_mask = 8'h01;
    bus.cfg_trig_mask = 8'h00;
    pulseCmd(1, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(8'h01, 16'hC000 + 16'(i), ent[i]);
    checks++; if (bus.st_wrapped !== 1'b1) begin failures++; $display("[TB] FAIL wrap_wrapped got=%b exp=1", bus.st_wrapped); end
    checks++; if (bus.st_wr_ptr !== 4'd4) begin failures++; $display("[TB] FAIL wrap_wr_ptr got=%0d exp=4", bus.st_wr_ptr); end
    checks++; if (bus.st_state !== 2'd1) begin failures++; $display("[TB] FAIL wrap_state got=%0d exp=1", bus.st_state); end
    ra.push_back(3); re.push_back(ent[19]);
    ra.push_back(4); re.push_back(ent[4]);
    ra.push_back(0); re.push_back(ent[16]);
    n = ra.size();
    for (int i = 0; i < n + 3; i++) begin
      checks++;
      if (bus.rd_valid !== (i >= 2 && i < n + 2)) begin
        failures++; $display("[TB] FAIL wrap_rd_valid[%0d] got=%b", i, bus.rd_valid);
      end
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL wrap_rd_extra got=%h exp=none", bus.rd_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rd_data !== exp) begin failures++; $display("[TB] FAIL wrap_rd_data got=%h exp=%h", bus.rd_data, exp); end
        end
      end
      if (i < n) begin expQ.push_back(re[i]); bus.rd_req = 1; bus.rd_addr = ra[i]; end
      else bus.rd_req = 0;
      @(negedge pClk);
    end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL wrap_rd_missing got=%0d exp=0", expQ.size()); expQ.delete(); end
  endtask

  task automatic test_stop_trigger();
    logic [63:0] e;
    bus.cfg_trig_mask = 8'h80;
    bus.cfg_stop = 1'b1;
    applyStimulus(8'h80, 16'hD000, e);
    bus.cfg_stop = 1'b0;
    checks++; if (bus.st_state !== 2'd3) begin failures++; $display("[TB] FAIL stop_state got=%0d exp=3", bus.st_state); end
    checks++; if (bus.st_triggered !== 1'b0) begin failures++; $display("[TB] FAIL stop_triggered got=%b exp=0", bus.st_triggered); end
    checks++; if (bus.st_wr_ptr !== 4'd4) begin failures++; $display("[TB] FAIL stop_wr_ptr got=%0d exp=4", bus.st_wr_ptr); end
    pulseCmd(1, 0, 1);
    checks++; if (bus.st_state !== 2'd0) begin failures++; $display("[TB] FAIL armclr_state got=%0d exp=0", bus.st_state); end
    checks++; if (bus.st_wr_ptr !== 4'd0) begin failures++; $display("[TB] FAIL armclr_wr_ptr got=%0d exp=0", bus.st_wr_ptr); end
    checks++; if (bus.st_wrapped !== 1'b0) begin failures++; $display("[TB] FAIL armclr_wrapped got=%b exp=0", bus.st_wrapped); end
    pulseCmd(0, 1, 0);
    checks++; if (bus.st_state !== 2'd0) begin failures++; $display("[TB] FAIL idle_stop_state got=%0d exp=0", bus.st_state); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] oldE;
    logic [63:0] newE;
    logic [63:0] exp;
    bus.cfg_capt_mask = 8'h00;
    bus.cfg_trig_mask = 8'h80;
    bus.cfg_post_cnt  = 4'd0;
    pulseCmd(1, 0, 0);
    applyStimulus(8'h80, 16'hE000, oldE);
    checks++; if (bus.st_state !== 2'd3) begin failures++; $display("[TB] FAIL p0_state got=%0d exp=3", bus.st_state); end
    checks++; if (bus.st_wr_ptr !== 4'd1) begin failures++; $display("[TB] FAIL p0_wr_ptr got=%0d exp=1", bus.st_wr_ptr); end
    checks++; if (bus.st_trig_ptr !== 4'd0) begin failures++; $display("[TB] FAIL p0_trig_ptr got=%0d exp=0", bus.st_trig_ptr); end
    checks++; if (bus.st_triggered !== 1'b1) begin failures++; $display("[TB] FAIL p0_triggered got=%b exp=1", bus.st_triggered); end
    bus.cfg_capt_mask = 8'h01;
    bus.cfg_trig_mask = 8'h00;
    pulseCmd(1, 0, 0);
    newE = {32'(cycleCnt), 8'h01, 16'hE001, 8'h00};
    // Cycle 0 writes address 0 while reading it; cycle 1 reads it again.
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rd_valid !== (i == 2 || i == 3)) begin
        failures++; $display("[TB] FAIL b2b_rd_valid[%0d] got=%b", i, bus.rd_valid);
      end
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL b2b_rd_extra got=%h exp=none", bus.rd_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rd_data !== exp) begin failures++; $display("[TB] FAIL b2b_rd_data got=%h exp=%h", bus.rd_data, exp); end
        end
      end
      bus.ev_vec = (i == 0) ? 8'h01 : 8'h00;
      bus.ev_tag = (i == 0) ? 16'hE001 : 16'h0000;
      if (i < 2) begin expQ.push_back(i == 0 ? oldE : newE); bus.rd_req = 1; bus.rd_addr = '0; end
      else bus.rd_req = 0;
      @(negedge pClk);
    end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL b2b_rd_missing got=%0d exp=0", expQ.size()); expQ.delete(); end
  endtask

  task automatic test_reset_mid_post();
    logic [63:0]    e;
    logic [63:0]    eMid;
    logic [DL2-1:0] ra[$];
    logic [63:0]    re[$];
    logic [63:0]    exp;
    int             n;
    pulseCmd(0, 0, 1);
    bus.cfg_capt_mask = 8'hFF;
    bus.cfg_trig_mask = 8'h80;
    bus.cfg_post_cnt  = 4'd8;
    pulseCmd(1, 0, 0);
    applyStimulus(8'h80, 16'hF000, e);
    applyStimulus(8'h01, 16'hF001, eMid);
    checks++; if (bus.st_state !== 2'd2) begin failures++; $display("[TB] FAIL mid_state_pre got=%0d exp=2", bus.st_state); end
    #2 rstN = 1'b0;
    #1;
    checks++; if (bus.st_state !== 2'd0) begin failures++; $display("[TB] FAIL mid_state got=%0d exp=0", bus.st_state); end
    checks++; if (bus.st_wr_ptr !== '0) begin failures++; $display("[TB] FAIL mid_wr_ptr got=%0d exp=0", bus.st_wr_ptr); end
    checks++; if (bus.st_triggered !== 1'b0) begin failures++; $display("[TB] FAIL mid_triggered got=%b exp=0", bus.st_triggered); end
    checks++; if (bus.st_trig_ptr !== '0) begin failures++; $display("[TB] FAIL mid_trig_ptr got=%0d exp=0", bus.st_trig_ptr); end
    @(negedge pClk);
    rstN = 1'b1;
    bus.cfg_capt_mask = 8'h01;
    bus.cfg_trig_mask = 8'h00;
    pulseCmd(1, 0, 0);
    applyStimulus(8'h01, 16'hF100, e);
    checks++; if (bus.st_state !== 2'd1) begin failures++; $display("[TB] FAIL rearm_state got=%0d exp=1", bus.st_state); end
    checks++; if (bus.st_wr_ptr !== 4'd1) begin failures++; $display("[TB] FAIL rearm_wr_ptr got=%0d exp=1", bus.st_wr_ptr); end
    ra.push_back(0); re.push_back(e);
    ra.push_back(1); re.push_back(eMid);
    n = ra.size();
    for (int i = 0; i < n + 3; i++) begin
      checks++;
      if (bus.rd_valid !== (i >= 2 && i < n + 2)) begin
        failures++; $display("[TB] FAIL rearm_rd_valid[%0d] got=%b", i, bus.rd_valid);
      end
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL rearm_rd_extra got=%h exp=none", bus.rd_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rd_data !== exp) begin failures++; $display("[TB] FAIL rearm_rd_data got=%h exp=%h", bus.rd_data, exp); end
        end
      end
      if (i < n) begin expQ.push_back(re[i]); bus.rd_req = 1; bus.rd_addr = ra[i]; end
      else bus.rd_req = 0;
      @(negedge pClk);
    end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL rearm_rd_missing got=%0d exp=0", expQ.size()); expQ.delete(); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_trigger_post();
    test_wrap();
    test_stop_trigger();
    test_back_to_back();
    test_reset_mid_post();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
